// File: rtl/demux_1_3_if.sv
// ----------------------------------------------------------------------------
// demux_1_3_if
//
// Handshake bundle for the registered 1-to-3 demultiplexer.
//
// Signals:
//   in_valid / in_ready / in_data / in_sel    producer side (one word + 2-bit
//                                             destination code)
//   out_{a,b,c}_valid / out_{a,b,c}_ready     one valid/ready pair per sink
//   out_data                                  head word, shared by all sinks
//   bad_sel                                   sticky illegal-select flag
//   drop_cnt                                  saturating count of dropped words
//
// Modports:
//   master  the environment: drives the producer side and the sink readies
//   slave   the demultiplexer itself
// ----------------------------------------------------------------------------
interface demux_1_3_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;

    logic             out_a_valid;
    logic             out_b_valid;
    logic             out_c_valid;
    logic             out_a_ready;
    logic             out_b_ready;
    logic             out_c_ready;
    logic [WIDTH-1:0] out_data;

    logic             bad_sel;
    logic [7:0]       drop_cnt;

    modport master (
        output in_valid, in_data, in_sel,
        output out_a_ready, out_b_ready, out_c_ready,
        input  in_ready,
        input  out_a_valid, out_b_valid, out_c_valid, out_data,
        input  bad_sel, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel,
        input  out_a_ready, out_b_ready, out_c_ready,
        output in_ready,
        output out_a_valid, out_b_valid, out_c_valid, out_data,
        output bad_sel, drop_cnt
    );
endinterface

// File: rtl/demux_1_3.sv
// ----------------------------------------------------------------------------
// demux_1_3
//
// Registered 1-to-3 demultiplexer with valid/ready handshakes. A word and its
// 2-bit destination code are buffered and presented to exactly one of three
// sinks (A = 2'b00, B = 2'b01, C = 2'b10). Words leave in strict arrival
// order; a stalled head blocks everything behind it. Words carrying the
// illegal code 2'b11 are consumed and discarded, setting the sticky bad_sel
// flag and bumping the saturating drop_cnt.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active high
//   bus   demux_1_3_if.slave handshake bundle (see the interface header)
//
// Build option:
//   DEMUX_SKID_EN  defined   -> 2-entry buffer, in_ready is purely registered
//                  undefined -> 1-entry buffer, in_ready also goes high when
//                               the head pops in the same cycle (combinational
//                               path from out_x_ready to in_ready)
// ----------------------------------------------------------------------------
module demux_1_3 #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    demux_1_3_if.slave bus
);

    localparam logic [1:0] SEL_BAD = 2'b11;

`ifdef DEMUX_SKID_EN
    localparam int DEPTH = 2;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
`else
    localparam int DEPTH = 1;
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;
`endif

    state_t state_reg;
    state_t state_next;

    // Entry 0 is always the head; entry 1 (skid build only) is the word
    // queued behind it. Entry 0 is never cleared on pop so out_data keeps
    // the last word presented while the buffer is empty.
    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [1:0]       sel_reg  [DEPTH];

    logic             bad_sel_reg;
    logic [7:0]       drop_cnt_reg;

    logic [2:0]       ready_vec;
    logic [2:0]       valid_vec;
    logic             occupied;
    logic             pop;
    logic             in_ready_int;
    logic             accept;
    logic             push;
    logic             drop;
    logic             load_head;
`ifdef DEMUX_SKID_EN
    logic             head_from_in;   // 0: head refills from entry 1
    logic             load_tail;
`endif

    assign ready_vec = {bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};
    assign occupied  = (state_reg != EMPTY);

    // One valid per sink, decoded from the stored head code only, so the
    // outputs never see in_sel/in_data combinationally.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sink
            assign valid_vec[gi] = occupied && (sel_reg[0] == 2'(gi));
        end
    endgenerate

    // Only the ready of the sink that currently owns the head matters.
    assign pop = |(valid_vec & ready_vec);

`ifdef DEMUX_SKID_EN
    assign in_ready_int = (state_reg != TWO);
`else
    assign in_ready_int = !occupied || pop;
`endif

    assign accept = bus.in_valid && in_ready_int;
    assign push   = accept && (bus.in_sel != SEL_BAD);
    assign drop   = accept && (bus.in_sel == SEL_BAD);

    // ------------------------------------------------------------------
    // Occupancy state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and buffer-write decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load_head  = 1'b0;
`ifdef DEMUX_SKID_EN
        head_from_in = 1'b1;
        load_tail    = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Incoming word replaces the departing head directly.
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = TWO;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_next   = ONE;
                    load_head    = 1'b1;
                    head_from_in = 1'b0;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
`else
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next = FULL;
                    load_head  = 1'b1;
                end
            end
            FULL: begin
                if (push) begin
                    // Pop and accept together: head is replaced, stays FULL.
                    load_head = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
`endif
    end

    // ------------------------------------------------------------------
    // Buffer storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
                sel_reg[i]  <= '0;
            end
        end else begin
            if (load_head) begin
`ifdef DEMUX_SKID_EN
                if (head_from_in) begin
                    data_reg[0] <= bus.in_data;
                    sel_reg[0]  <= bus.in_sel;
                end else begin
                    data_reg[0] <= data_reg[1];
                    sel_reg[0]  <= sel_reg[1];
                end
`else
                data_reg[0] <= bus.in_data;
                sel_reg[0]  <= bus.in_sel;
`endif
            end
`ifdef DEMUX_SKID_EN
            if (load_tail) begin
                data_reg[1] <= bus.in_data;
                sel_reg[1]  <= bus.in_sel;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Illegal-select bookkeeping: sticky flag and saturating counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_sel_reg  <= 1'b0;
            drop_cnt_reg <= 8'h00;
        end else if (drop) begin
            bad_sel_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'h01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready_int;
    assign bus.out_a_valid = valid_vec[0];
    assign bus.out_b_valid = valid_vec[1];
    assign bus.out_c_valid = valid_vec[2];
    assign bus.out_data    = data_reg[0];
    assign bus.bad_sel     = bad_sel_reg;
    assign bus.drop_cnt    = drop_cnt_reg;

endmodule
